// File: rtl/riscv_v_pkg.sv
// Shared types and helpers for the sequential vector execute unit.
// Contents: opcode / element-width / FSM state enums and element-count helpers.
package riscv_v_pkg;

    localparam int unsigned OPC_W  = 4;
    localparam int unsigned SEW_W  = 2;
    localparam int unsigned NUM_EW = 4;

    typedef enum logic [OPC_W-1:0] {
        OP_ADD    = 4'd0,
        OP_SUB    = 4'd1,
        OP_AND    = 4'd2,
        OP_OR     = 4'd3,
        OP_XOR    = 4'd4,
        OP_MINU   = 4'd5,
        OP_MAXU   = 4'd6,
        OP_MIN    = 4'd7,
        OP_MAX    = 4'd8,
        OP_REDSUM = 4'd9
    } opcode_e;

    typedef enum logic [SEW_W-1:0] {
        SEW_8  = 2'd0,
        SEW_16 = 2'd1,
        SEW_32 = 2'd2,
        SEW_64 = 2'd3
    } sew_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Element width in bits for an encoded sew.
    function automatic int unsigned elem_bits(input logic [SEW_W-1:0] sew);
        return 32'd8 << sew;
    endfunction

    // Number of sew-wide elements that fit in a field of 'bits' bits.
    function automatic int unsigned elems_per(input int unsigned bits, input logic [SEW_W-1:0] sew);
        return bits >> (32'd3 + 32'(sew));
    endfunction

endpackage

// File: rtl/riscv_v_exe_seq_lane.sv
// Combinational per-beat ALU, partitioned into sew-wide elements.
// Ports: i_op/i_sew/i_illegal select the operation; i_beat locates the beat in
// the vector; i_vl/i_vstart/i_vm/i_mask form the active window; i_a/i_b/i_old
// are the beat slices of vs2/vs1/vd. o_res is the beat result (inactive
// elements keep i_old), o_sum the sum of active i_a elements for reductions.
module riscv_v_exe_seq_lane
    import riscv_v_pkg::*;
#(
    parameter  int unsigned VLEN  = 256,
    parameter  int unsigned DP_W  = 64,
    localparam int unsigned BEATS = VLEN / DP_W,
    localparam int unsigned BC_W  = (BEATS > 1) ? $clog2(BEATS) : 1,
    localparam int unsigned VS_W  = $clog2(VLEN / 8),
    localparam int unsigned VL_W  = VS_W + 1
) (
    input  logic [OPC_W-1:0]  i_op,
    input  logic [SEW_W-1:0]  i_sew,
    input  logic              i_illegal,
    input  logic [BC_W-1:0]   i_beat,
    input  logic [VL_W-1:0]   i_vl,
    input  logic [VS_W-1:0]   i_vstart,
    input  logic              i_vm,
    input  logic [VLEN/8-1:0] i_mask,
    input  logic [DP_W-1:0]   i_a,
    input  logic [DP_W-1:0]   i_b,
    input  logic [DP_W-1:0]   i_old,
    output logic [DP_W-1:0]   o_res,
    output logic [63:0]       o_sum
);

    logic [DP_W-1:0] w_res_s [NUM_EW];
    logic [63:0]     w_sum_s [NUM_EW];

    // One element-partitioned datapath per supported width; i_sew picks one.
    for (genvar s = 0; s < NUM_EW; s++) begin : g_sew
        localparam int unsigned EW = elem_bits(SEW_W'(s));
        if (EW <= DP_W) begin : g_on
            localparam int unsigned NE = DP_W / EW;
            logic [DP_W-1:0] w_res;
            logic [63:0]     w_sum;
            logic [EW-1:0]   w_ea, w_eb, w_eo, w_er;
            int unsigned     w_idx;
            logic            w_act;

            always_comb begin
                w_res = i_old;
                w_sum = '0;
                w_ea  = '0;
                w_eb  = '0;
                w_eo  = '0;
                w_er  = '0;
                w_idx = 0;
                w_act = 1'b0;
                for (int unsigned e = 0; e < NE; e++) begin
                    w_ea  = i_a[e*EW +: EW];
                    w_eb  = i_b[e*EW +: EW];
                    w_eo  = i_old[e*EW +: EW];
                    w_idx = NE * 32'(i_beat) + e;
                    w_act = !i_illegal && (w_idx >= 32'(i_vstart)) && (w_idx < 32'(i_vl))
                            && (i_vm || i_mask[w_idx[VS_W-1:0]]);
                    case (i_op)
                        OP_ADD:  w_er = w_ea + w_eb;
                        OP_SUB:  w_er = w_ea - w_eb;
                        OP_AND:  w_er = w_ea & w_eb;
                        OP_OR:   w_er = w_ea | w_eb;
                        OP_XOR:  w_er = w_ea ^ w_eb;
                        OP_MINU: w_er = (w_ea < w_eb) ? w_ea : w_eb;
                        OP_MAXU: w_er = (w_ea > w_eb) ? w_ea : w_eb;
                        OP_MIN:  w_er = ($signed(w_ea) < $signed(w_eb)) ? w_ea : w_eb;
                        OP_MAX:  w_er = ($signed(w_ea) > $signed(w_eb)) ? w_ea : w_eb;
                        default: w_er = w_eo;
                    endcase
                    // Reductions leave every element undisturbed; only the sum moves.
                    if (w_act && (i_op != OP_REDSUM)) begin
                        w_res[e*EW +: EW] = w_er;
                    end
                    if (w_act && (i_op == OP_REDSUM)) begin
                        w_sum = w_sum + 64'(w_ea);
                    end
                end
            end

            assign w_res_s[s] = w_res;
            assign w_sum_s[s] = w_sum;
        end else begin : g_off
            assign w_res_s[s] = i_old;
            assign w_sum_s[s] = '0;
        end
    end

    assign o_res = w_res_s[i_sew];
    assign o_sum = w_sum_s[i_sew];

endmodule

// File: rtl/riscv_v_exe_seq.sv
// Sequential vector execute unit: one DP_W-bit beat per cycle over a VLEN-bit
// vector, with masking, vstart/vl window, and optional sum reduction.
// Macro RISCV_V_EXE_SEQ_REDUCT_EN enables REDSUM; otherwise opcode 9 is illegal.
// Ports: clk, rst (sync, active-high); in_valid/in_ready request handshake with
// opcode, sew, vl, vstart, vm, srca (vs2), srcb (vs1), vd_old, mask; kill aborts;
// out_valid/out_ready result handshake with result and illegal.
module riscv_v_exe_seq
    import riscv_v_pkg::*;
#(
    parameter  int unsigned VLEN  = 256,
    parameter  int unsigned DP_W  = 64,
    localparam int unsigned BEATS = VLEN / DP_W,
    localparam int unsigned BC_W  = (BEATS > 1) ? $clog2(BEATS) : 1,
    localparam int unsigned VS_W  = $clog2(VLEN / 8),
    localparam int unsigned VL_W  = VS_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPC_W-1:0]  opcode,
    input  logic [SEW_W-1:0]  sew,
    input  logic [VL_W-1:0]   vl,
    input  logic [VS_W-1:0]   vstart,
    input  logic              vm,
    input  logic [VLEN-1:0]   srca,
    input  logic [VLEN-1:0]   srcb,
    input  logic [VLEN-1:0]   vd_old,
    input  logic [VLEN/8-1:0] mask,
    input  logic              kill,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [VLEN-1:0]   result,
    output logic              illegal
);

    state_e            r_state, w_state_nxt;
    logic [BC_W-1:0]   r_beat;
    logic [OPC_W-1:0]  r_op;
    logic [SEW_W-1:0]  r_sew;
    logic [VL_W-1:0]   r_vl;
    logic [VS_W-1:0]   r_vstart;
    logic              r_vm;
    logic [VLEN/8-1:0] r_mask;
    logic [VLEN-1:0]   r_srca, r_srcb, r_old, r_result, w_result_nxt;
    logic              r_op_illegal, r_illegal;
    logic              w_accept, w_last, w_in_illegal;
    logic [VL_W-1:0]   w_vlmax, w_vl_clamp;
    logic [DP_W-1:0]   w_a, w_b, w_old, w_lane_res;
    logic [63:0]       w_lane_sum;

    assign w_accept = (r_state == S_IDLE) && in_valid && !kill;
    assign w_last   = (r_beat == BC_W'(BEATS - 1));

    // Clamp vl to the element capacity of the register at the requested width.
    assign w_vlmax    = VL_W'(elems_per(VLEN, sew));
    assign w_vl_clamp = (vl > w_vlmax) ? w_vlmax : vl;

`ifdef RISCV_V_EXE_SEQ_REDUCT_EN
    assign w_in_illegal = (opcode > OP_REDSUM);
`else
    assign w_in_illegal = (opcode >= OP_REDSUM);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; kill wins over both handshakes.
    always_comb begin
        w_state_nxt = r_state;
        if (kill) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (in_valid)  w_state_nxt = S_RUN;
                S_RUN:   if (w_last)    w_state_nxt = S_DONE;
                S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;
    assign illegal   = r_illegal;

    assign w_a   = r_srca[r_beat*DP_W +: DP_W];
    assign w_b   = r_srcb[r_beat*DP_W +: DP_W];
    assign w_old = r_old[r_beat*DP_W +: DP_W];

    riscv_v_exe_seq_lane #(
        .VLEN (VLEN),
        .DP_W (DP_W)
    ) u_lane (
        .i_op      (r_op),
        .i_sew     (r_sew),
        .i_illegal (r_op_illegal),
        .i_beat    (r_beat),
        .i_vl      (r_vl),
        .i_vstart  (r_vstart),
        .i_vm      (r_vm),
        .i_mask    (r_mask),
        .i_a       (w_a),
        .i_b       (w_b),
        .i_old     (w_old),
        .o_res     (w_lane_res),
        .o_sum     (w_lane_sum)
    );

`ifdef RISCV_V_EXE_SEQ_REDUCT_EN
    logic [63:0] r_acc, w_acc_fin;
    logic        w_red_fin;

    // Running reduction: seeded with vs1[0], adds active vs2 elements each beat.
    assign w_acc_fin = r_acc + w_lane_sum;
    // Element 0 is only written back when the active window is non-empty.
    assign w_red_fin = (r_state == S_RUN) && w_last && (r_op == OP_REDSUM)
                       && (VL_W'(r_vstart) < r_vl);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (w_accept) begin
            r_acc <= 64'(srcb);
        end else if ((r_state == S_RUN) && !kill) begin
            r_acc <= w_acc_fin;
        end
    end
`else
    logic w_sum_unused;
    assign w_sum_unused = ^w_lane_sum;
`endif

    // Merge the current beat (and, on the final reduction beat, element 0).
    always_comb begin
        w_result_nxt = r_result;
        w_result_nxt[r_beat*DP_W +: DP_W] = w_lane_res;
`ifdef RISCV_V_EXE_SEQ_REDUCT_EN
        if (w_red_fin) begin
            case (r_sew)
                SEW_8:   w_result_nxt[7:0]  = w_acc_fin[7:0];
                SEW_16:  w_result_nxt[15:0] = w_acc_fin[15:0];
                SEW_32:  w_result_nxt[31:0] = w_acc_fin[31:0];
                default: w_result_nxt[63:0] = w_acc_fin;
            endcase
        end
`endif
    end

    // Operand capture, beat sequencing and result/illegal registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat       <= '0;
            r_op         <= '0;
            r_sew        <= '0;
            r_vl         <= '0;
            r_vstart     <= '0;
            r_vm         <= 1'b0;
            r_mask       <= '0;
            r_srca       <= '0;
            r_srcb       <= '0;
            r_old        <= '0;
            r_op_illegal <= 1'b0;
            r_illegal    <= 1'b0;
            r_result     <= '0;
        end else if (kill) begin
            r_beat    <= '0;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_beat       <= '0;
                        r_op         <= opcode;
                        r_sew        <= sew;
                        r_vl         <= w_vl_clamp;
                        r_vstart     <= vstart;
                        r_vm         <= vm;
                        r_mask       <= mask;
                        r_srca       <= srca;
                        r_srcb       <= srcb;
                        r_old        <= vd_old;
                        r_op_illegal <= w_in_illegal;
                    end
                end
                S_RUN: begin
                    r_result <= w_result_nxt;
                    r_beat   <= w_last ? '0 : r_beat + BC_W'(1);
                    if (w_last) begin
                        r_illegal <= r_op_illegal;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_illegal <= 1'b0;
                    end
                end
                default: begin
                    r_beat <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_v_exe_seq.sv
// Directed self-checking bench for riscv_v_exe_seq (VLEN=256, DP_W=64).
module tb_riscv_v_exe_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   opcode;
    logic [1:0]   sew;
    logic [5:0]   vl;
    logic [4:0]   vstart;
    logic         vm;
    logic [255:0] srca, srcb, vd_old;
    logic [31:0]  mask;
    logic         kill;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] result;
    logic         illegal;

    int n_chk  = 0;
    int n_fail = 0;

    riscv_v_exe_seq #(.VLEN(256), .DP_W(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .sew       (sew),
        .vl        (vl),
        .vstart    (vstart),
        .vm        (vm),
        .srca      (srca),
        .srcb      (srcb),
        .vd_old    (vd_old),
        .mask      (mask),
        .kill      (kill),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected end before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op from a negedge in IDLE; return at the negedge where out_valid is seen.
    // lat counts rising edges, including the accepting one, up to out_valid.
    task automatic do_op(input logic [3:0] op, input logic [1:0] sw, input logic [5:0] v_l,
                         input logic [4:0] v_st, input logic v_m, input logic [31:0] m,
                         input logic [255:0] a, input logic [255:0] b, input logic [255:0] o,
                         output logic [255:0] res, output logic ill, output int lat);
        opcode = op; sew = sw; vl = v_l; vstart = v_st; vm = v_m; mask = m;
        srca = a; srcb = b; vd_old = o; in_valid = 1'b1;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            in_valid = 1'b0;
        end while (!out_valid && lat < 20);
        res = result;
        ill = illegal;
    endtask

    // With out_ready high, the DONE cycle hands off and out_valid drops next cycle.
    task automatic handoff(input string tag);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_ov_drop"}, 256'(out_valid), 256'(1'b0));
        chk({tag, "_in_ready"}, 256'(in_ready), 256'(1'b1));
    endtask

    initial begin
        logic [255:0] res, exp;
        logic         ill, ov_seen;
        int           lat;

        rst = 1'b1; in_valid = 1'b0; opcode = '0; sew = '0; vl = '0; vstart = '0;
        vm = 1'b1; srca = '0; srcb = '0; vd_old = '0; mask = '0; kill = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 256'(in_ready), 256'(1'b1));
        chk("rst_out_valid", 256'(out_valid), 256'(1'b0));
        chk("rst_illegal", 256'(illegal), 256'(1'b0));
        chk("rst_result", result, 256'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 256'(in_ready), 256'(1'b1));

        // ADD sew=8, all 0x01 + 0x01.
        do_op(4'd0, 2'd0, 6'd32, 5'd0, 1'b1, 32'h0, {32{8'h01}}, {32{8'h01}}, {32{8'h5A}}, res, ill, lat);
        chk("add8_res", res, {32{8'h02}});
        chk("add8_lat", 256'(lat), 256'(5));
        chk("add8_ill", 256'(ill), 256'(1'b0));
        handoff("add8");

        // ADD sew=8 wrap: 0xFF+0x01 must not carry into the neighbour.
        do_op(4'd0, 2'd0, 6'd32, 5'd0, 1'b1, 32'h0, {32{8'hFF}}, {32{8'h01}}, '0, res, ill, lat);
        chk("add8_wrap", res, 256'(0));
        handoff("add8w");

        // ADD sew=64 with vl=20 clamped to 4: carry stays inside the element.
        do_op(4'd0, 2'd3, 6'd20, 5'd0, 1'b1, 32'h0, {4{64'h0000_0000_FFFF_FFFF}}, {4{64'h1}},
              {4{64'hDEAD}}, res, ill, lat);
        chk("add64_clamp", res, {4{64'h0000_0001_0000_0000}});
        handoff("add64");

        // MIN / MINU sew=32, elem0 -1 vs 1.
        do_op(4'd7, 2'd2, 6'd8, 5'd0, 1'b1, 32'h0, {224'h0, 32'hFFFF_FFFF}, {224'h0, 32'h1},
              {8{32'h5555_5555}}, res, ill, lat);
        chk("min32", res, {224'h0, 32'hFFFF_FFFF});
        handoff("min32");
        do_op(4'd5, 2'd2, 6'd8, 5'd0, 1'b1, 32'h0, {224'h0, 32'hFFFF_FFFF}, {224'h0, 32'h1},
              {8{32'h5555_5555}}, res, ill, lat);
        chk("minu32", res, {224'h0, 32'h1});
        handoff("minu32");

        // MAX / MAXU sew=64, elem0 INT64_MIN vs 1.
        do_op(4'd8, 2'd3, 6'd4, 5'd0, 1'b1, 32'h0, {192'h0, 64'h8000_0000_0000_0000}, {192'h0, 64'h1},
              '0, res, ill, lat);
        chk("max64", res, {192'h0, 64'h1});
        handoff("max64");
        do_op(4'd6, 2'd3, 6'd4, 5'd0, 1'b1, 32'h0, {192'h0, 64'h8000_0000_0000_0000}, {192'h0, 64'h1},
              '0, res, ill, lat);
        chk("maxu64", res, {192'h0, 64'h8000_0000_0000_0000});
        handoff("maxu64");

        // SUB sew=16, window [2,10), mask 0x155: only elements 2,4,6,8 change.
        do_op(4'd1, 2'd1, 6'd10, 5'd2, 1'b0, 32'h155, {16{16'h0010}}, {16{16'h0003}},
              {16{16'hAAAA}}, res, ill, lat);
        exp = {16{16'hAAAA}};
        for (int e = 2; e <= 8; e += 2) exp[e*16 +: 16] = 16'h000D;
        chk("sub16_mask", res, exp);
        handoff("sub16");

        // Empty windows leave vd_old untouched.
        do_op(4'd4, 2'd0, 6'd0, 5'd0, 1'b1, 32'h0, {32{8'hAA}}, {32{8'hFF}}, {32{8'h3C}}, res, ill, lat);
        chk("xor_vl0", res, {32{8'h3C}});
        handoff("xorvl0");
        do_op(4'd3, 2'd0, 6'd5, 5'd5, 1'b1, 32'h0, {32{8'hAA}}, {32{8'h0F}}, {32{8'h3C}}, res, ill, lat);
        chk("or_vstart_ge_vl", res, {32{8'h3C}});
        handoff("orvst");

        // AND sew=8, partial vl=3.
        do_op(4'd2, 2'd0, 6'd3, 5'd0, 1'b1, 32'h0, {32{8'hF0}}, {32{8'h3C}}, {32{8'h11}}, res, ill, lat);
        chk("and8_vl3", res, {{29{8'h11}}, {3{8'h30}}});
        handoff("and8");

        // REDSUM sew=8 and sew=16 (modulo), then with vl=0.
        do_op(4'd9, 2'd0, 6'd32, 5'd0, 1'b1, 32'h0, {32{8'h01}}, {248'h0, 8'h05}, {32{8'h77}}, res, ill, lat);
`ifdef RISCV_V_EXE_SEQ_REDUCT_EN
        chk("redsum8", res, {{31{8'h77}}, 8'h25});
        chk("redsum8_ill", 256'(ill), 256'(1'b0));
`else
        chk("redsum8_off", res, {32{8'h77}});
        chk("redsum8_off_ill", 256'(ill), 256'(1'b1));
`endif
        handoff("red8");
        do_op(4'd9, 2'd1, 6'd16, 5'd0, 1'b1, 32'h0, {16{16'h1000}}, {240'h0, 16'h0001}, {16{16'h7777}},
              res, ill, lat);
`ifdef RISCV_V_EXE_SEQ_REDUCT_EN
        chk("redsum16_wrap", res, {{15{16'h7777}}, 16'h0001});
`else
        chk("redsum16_off", res, {16{16'h7777}});
`endif
        handoff("red16");
        do_op(4'd9, 2'd0, 6'd0, 5'd0, 1'b1, 32'h0, {32{8'h01}}, {248'h0, 8'h05}, {32{8'h77}}, res, ill, lat);
        chk("redsum_vl0", res, {32{8'h77}});
        handoff("redvl0");

        // Illegal opcode 12.
        do_op(4'd12, 2'd0, 6'd32, 5'd0, 1'b1, 32'h0, {32{8'h01}}, {32{8'h01}}, {32{8'h99}}, res, ill, lat);
        chk("illop_res", res, {32{8'h99}});
        chk("illop_ill", 256'(ill), 256'(1'b1));
        handoff("illop");
        chk("illop_ill_clear", 256'(illegal), 256'(1'b0));

        // Back-pressure: DONE held 7 cycles, then a single out_ready cycle.
        out_ready = 1'b0;
        do_op(4'd4, 2'd0, 6'd32, 5'd0, 1'b1, 32'h0, {32{8'hAA}}, {32{8'hFF}}, '0, res, ill, lat);
        chk("stall_first", res, {32{8'h55}});
        for (int k = 0; k < 7; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("stall_res", result, {32{8'h55}});
            chk("stall_in_ready", 256'(in_ready), 256'(1'b0));
            chk("stall_out_valid", 256'(out_valid), 256'(1'b1));
        end
        out_ready = 1'b1;
        handoff("stall");

        // kill during RUN beat 1.
        ov_seen = 1'b0;
        opcode = 4'd0; sew = 2'd0; vl = 6'd32; vstart = 5'd0; vm = 1'b1;
        srca = {32{8'h10}}; srcb = {32{8'h20}}; vd_old = '0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("kill_run_in_ready", 256'(in_ready), 256'(1'b0));
        @(posedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        @(negedge clk);
        kill = 1'b0;
        chk("kill_in_ready", 256'(in_ready), 256'(1'b1));
        chk("kill_out_valid", 256'(out_valid), 256'(1'b0));
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            ov_seen = ov_seen | out_valid;
        end
        chk("kill_no_ov", 256'(ov_seen), 256'(1'b0));
        do_op(4'd0, 2'd0, 6'd32, 5'd0, 1'b1, 32'h0, {32{8'h03}}, {32{8'h04}}, '0, res, ill, lat);
        chk("kill_next_res", res, {32{8'h07}});
        chk("kill_next_lat", 256'(lat), 256'(5));
        handoff("killnx");

        // rst during RUN.
        ov_seen = 1'b0;
        opcode = 4'd0; srca = {32{8'h10}}; srcb = {32{8'h20}}; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rstrun_in_ready", 256'(in_ready), 256'(1'b1));
        chk("rstrun_out_valid", 256'(out_valid), 256'(1'b0));
        chk("rstrun_result", result, 256'(0));
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            ov_seen = ov_seen | out_valid;
        end
        chk("rstrun_no_ov", 256'(ov_seen), 256'(1'b0));
        do_op(4'd1, 2'd1, 6'd16, 5'd0, 1'b1, 32'h0, {16{16'h0100}}, {16{16'h0101}}, '0, res, ill, lat);
        chk("rstrun_next_res", res, {16{16'hFFFF}});
        chk("rstrun_next_lat", 256'(lat), 256'(5));
        handoff("rstnx");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
